// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset datapath: control-bus field
// values, instruction opcodes/functs and the internal ALU operation select.
package mc_pkg;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpRsvd  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SrcBReg   = 2'b00,
    SrcBFour  = 2'b01,
    SrcBImm   = 2'b10,
    SrcBImmSh = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PcSrcAlu    = 2'b00,
    PcSrcAluOut = 2'b01,
    PcSrcJump   = 2'b10,
    PcSrcHold   = 2'b11
  } pc_src_e;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;
  localparam logic [5:0] FunctOr  = 6'h25;
  localparam logic [5:0] FunctSlt = 6'h2A;

  localparam logic [5:0] OpcR    = 6'h00;
  localparam logic [5:0] OpcBeq  = 6'h04;
  localparam logic [5:0] OpcAddi = 6'h08;
  localparam logic [5:0] OpcLw   = 6'h23;
  localparam logic [5:0] OpcSw   = 6'h2B;
  localparam logic [5:0] OpcJ    = 6'h02;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4
  } alu_ctrl_e;

  // Reserved ALUOp and unknown functs fall back to add so odd control never wedges.
  function automatic alu_ctrl_e alu_decode(input logic [1:0] op, input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = AluAdd;
    case (op)
      AluOpSub: ctrl = AluSub;
      AluOpFunct: begin
        case (funct)
          FunctSub: ctrl = AluSub;
          FunctAnd: ctrl = AluAnd;
          FunctOr:  ctrl = AluOr;
          FunctSlt: ctrl = AluSlt;
          default:  ctrl = AluAdd;
        endcase
      end
      default: ctrl = AluAdd;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/mc_datapath_if.sv
// Control strobes from the multicycle FSM, opcode/zero feedback and the unified
// memory port, bundled as one bus between controller/memory and datapath.
interface mc_datapath_if;

  logic        RegDst;
  logic        ALUSrcA;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic        PCWrite;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  ALUOp;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;

  logic [5:0]  opcode;
  logic        zero;
  logic [31:0] pc;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite,
    output IorD, IRWrite, ALUOp, ALUSrcB, PCSource, mem_rdata,
    input  opcode, zero, pc, mem_addr, mem_wdata, mem_re, mem_we
  );

  modport slave (
    input  RegDst, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite,
    input  IorD, IRWrite, ALUOp, ALUSrcB, PCSource, mem_rdata,
    output opcode, zero, pc, mem_addr, mem_wdata, mem_re, mem_we
  );

endinterface

// File: rtl/mc_regfile.sv
// 32-entry register file: two combinational read ports, one posedge write port,
// register 0 hardwired to zero, synchronous clear on reset.
module mc_regfile #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       raddr1,
  input  logic [4:0]       raddr2,
  output logic [Width-1:0] rdata1,
  output logic [Width-1:0] rdata2,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [Width-1:0] wdata
);

  logic [Width-1:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Reads see the pre-write value when a write to the same register lands this cycle.
  always_comb begin
    rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
    rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: PC, IR, MDR, A, B, ALUOut, register file and
// inline ALU, all sequenced by the external control FSM through the bus.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  mc_datapath_if.slave bus
);

  logic [XLEN-1:0] pc_q, ir_q, mdr_q, a_q, b_q, alu_out_q;
  logic [XLEN-1:0] pc_d;
  logic            pc_en;

  logic [XLEN-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic [4:0]      rf_waddr;

  logic [XLEN-1:0] imm_sext, alu_a, alu_b, alu_result;
  alu_ctrl_e       alu_ctrl;
  logic            zero;

  mc_regfile #(
    .Width (XLEN)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (ir_q[25:21]),
    .raddr2 (ir_q[20:16]),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (bus.RegWrite),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  always_comb begin
    rf_waddr = bus.RegDst ? ir_q[15:11] : ir_q[20:16];
    rf_wdata = bus.MemtoReg ? mdr_q : alu_out_q;
  end

  always_comb begin
    imm_sext = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
    alu_a    = bus.ALUSrcA ? a_q : pc_q;
    alu_b    = b_q;
    unique case (alu_src_b_e'(bus.ALUSrcB))
      SrcBReg:   alu_b = b_q;
      SrcBFour:  alu_b = XLEN'(4);
      SrcBImm:   alu_b = imm_sext;
      SrcBImmSh: alu_b = imm_sext << 2;
      default:   alu_b = b_q;
    endcase
  end

  always_comb begin
    alu_ctrl   = alu_decode(bus.ALUOp, ir_q[5:0]);
    alu_result = alu_a + alu_b;
    case (alu_ctrl)
      AluAdd:  alu_result = alu_a + alu_b;
      AluSub:  alu_result = alu_a - alu_b;
      AluAnd:  alu_result = alu_a & alu_b;
      AluOr:   alu_result = alu_a | alu_b;
      AluSlt:  alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = alu_a + alu_b;
    endcase
    zero = (alu_result == '0);
  end

  // PCWrite and a taken branch both just enable the same single write.
  always_comb begin
    pc_en = bus.PCWrite | (bus.Branch & zero);
    pc_d  = pc_q;
    unique case (pc_src_e'(bus.PCSource))
      PcSrcAlu:    pc_d = alu_result;
      PcSrcAluOut: pc_d = alu_out_q;
      PcSrcJump:   pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
      PcSrcHold:   pc_d = pc_q;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      if (pc_en) begin
        pc_q <= pc_d;
      end
      if (bus.IRWrite) begin
        ir_q <= bus.mem_rdata;
      end
      mdr_q     <= bus.mem_rdata;
      a_q       <= rf_rdata1;
      b_q       <= rf_rdata2;
      alu_out_q <= alu_result;
    end
  end

  assign bus.opcode    = ir_q[31:26];
  assign bus.zero      = zero;
  assign bus.pc        = pc_q;
  assign bus.mem_addr  = bus.IorD ? alu_out_q : pc_q;
  assign bus.mem_wdata = b_q;
  assign bus.mem_re    = bus.MemRead;
  assign bus.mem_we    = bus.MemWrite;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: stimulus plays the control FSM and queues the
// expected outputs per cycle; a negedge monitor pops and compares them.
module tb_mc_datapath;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  mc_datapath_if bus ();

  mc_datapath #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int SigPc    = 0;
  localparam int SigOp    = 1;
  localparam int SigZero  = 2;
  localparam int SigAddr  = 3;
  localparam int SigWdata = 4;
  localparam int SigWe    = 5;

  typedef struct {
    int          at;
    int          sel;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   total  = 0;
  int   passed = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      SigPc:    return bus.pc;
      SigOp:    return {26'd0, bus.opcode};
      SigZero:  return {31'd0, bus.zero};
      SigAddr:  return bus.mem_addr;
      SigWdata: return bus.mem_wdata;
      default:  return {31'd0, bus.mem_we};
    endcase
  endfunction

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    chk_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      total++;
      if (e.at < cyc) begin
        $display("FAIL %s: check missed its cycle %0d (now %0d)", e.name, e.at, cyc);
      end else begin
        act = sample(e.sel);
        if (act === e.exp) passed++;
        else $display("FAIL %s: got %h, want %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input int sel, input logic [31:0] exp, input string name);
    sb.push_back('{cyc, sel, exp, name});
  endtask

  task automatic clr();
    bus.RegDst = 0; bus.ALUSrcA = 0; bus.MemtoReg = 0; bus.RegWrite = 0;
    bus.MemRead = 0; bus.MemWrite = 0; bus.Branch = 0; bus.PCWrite = 0;
    bus.IorD = 0; bus.IRWrite = 0; bus.ALUOp = 2'b00; bus.ALUSrcB = 2'b00;
    bus.PCSource = 2'b00; bus.mem_rdata = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic fetch(input logic [31:0] word);
    tick();
    bus.IRWrite = 1; bus.PCWrite = 1; bus.ALUSrcB = 2'b01; bus.MemRead = 1;
    bus.mem_rdata = word;
    chk(SigAddr, exp_pc, "fetch_addr");
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic decode();
    tick();
    bus.ALUSrcB = 2'b11;
  endtask

  task automatic ex_i();
    tick();
    bus.ALUSrcA = 1; bus.ALUSrcB = 2'b10;
  endtask

  task automatic ex_r();
    tick();
    bus.ALUSrcA = 1; bus.ALUOp = 2'b10;
  endtask

  task automatic ex_b();
    tick();
    bus.ALUSrcA = 1; bus.ALUOp = 2'b01; bus.Branch = 1; bus.PCSource = 2'b01;
  endtask

  task automatic wb(input logic rd);
    tick();
    bus.RegWrite = 1; bus.RegDst = rd;
  endtask

  // Load an IR whose rt names the register, let B capture it, then look at mem_wdata.
  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string name);
    tick();
    bus.IRWrite = 1;
    bus.mem_rdata = {6'h00, 5'd0, r, 16'h0000};
    tick();
    tick();
    chk(SigWdata, exp, name);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    exp_pc = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    chk(SigPc, 32'h0, "reset_pc");
    chk(SigOp, 32'h0, "reset_opcode");
    chk(SigAddr, 32'h0, "reset_mem_addr");
    chk(SigWe, 32'h0, "reset_mem_we");
    chk(SigZero, 32'h1, "reset_zero");

    // addi $8,$0,5
    fetch(32'h2008_0005);
    decode();
    chk(SigOp, 32'h08, "addi_opcode");
    chk(SigPc, 32'h4, "fetch_pc");
    ex_i();
    chk(SigZero, 32'h0, "addi_ex_zero");
    wb(1'b0);
    chk(SigWdata, 32'h0, "b_before_wb");
    tick();
    chk(SigWdata, 32'h0, "rf_read_old_on_write");
    tick();
    chk(SigWdata, 32'h5, "rf8_addi");

    // addi $9,$0,7
    fetch(32'h2009_0007);
    chk(SigPc, 32'h4, "pc_before_2nd_fetch");
    decode();
    ex_i();
    wb(1'b0);
    peek(5'd9, 32'h7, "rf9_addi");

    // sub $10,$8,$9
    fetch(32'h0109_5022);
    decode();
    ex_r();
    chk(SigZero, 32'h0, "sub_zero");
    wb(1'b1);
    peek(5'd10, 32'hFFFF_FFFE, "rf10_sub");

    // slt $10,$8,$9
    fetch(32'h0109_502A);
    decode();
    ex_r();
    wb(1'b1);
    peek(5'd10, 32'h1, "rf10_slt");

    // j 0x1 -> pc 4
    fetch(32'h0800_0001);
    decode();
    tick();
    bus.PCWrite = 1; bus.PCSource = 2'b10;
    tick();
    exp_pc = 32'h4;
    chk(SigPc, exp_pc, "jump_pc");

    // beq $8,$8,3 at pc 4: taken to 8 + 12
    fetch(32'h1108_0003);
    decode();
    chk(SigPc, 32'h8, "beq_id_pc");
    ex_b();
    chk(SigZero, 32'h1, "beq_eq_zero");
    tick();
    exp_pc = 32'd20;
    chk(SigPc, exp_pc, "beq_taken_pc");

    // beq $8,$9,3: not taken; then a store cycle through ALUOut
    fetch(32'h1109_0003);
    decode();
    ex_b();
    chk(SigZero, 32'h0, "beq_ne_zero");
    tick();
    bus.IorD = 1; bus.MemWrite = 1;
    chk(SigPc, 32'd24, "beq_not_taken_pc");
    chk(SigAddr, 32'hFFFF_FFFE, "iord_mem_addr");
    chk(SigWe, 32'h1, "store_mem_we");
    chk(SigWdata, 32'h7, "store_mem_wdata");

    // addi $0,$0,9 must not change $0
    tick();
    bus.IRWrite = 1; bus.mem_rdata = 32'h2000_0009;
    tick();
    ex_i();
    wb(1'b0);
    peek(5'd0, 32'h0, "rf0_ignored");

    // Reset during EX of sub, with write enables asserted
    fetch(32'h0109_5022);
    decode();
    tick();
    rst = 1'b1;
    bus.ALUSrcA = 1; bus.ALUOp = 2'b10; bus.RegWrite = 1; bus.RegDst = 1; bus.PCWrite = 1;
    tick();
    rst = 1'b0;
    chk(SigPc, 32'h0, "midop_reset_pc");
    chk(SigOp, 32'h0, "midop_reset_opcode");
    peek(5'd8, 32'h0, "rf8_cleared");
    peek(5'd9, 32'h0, "rf9_cleared");
    peek(5'd10, 32'h0, "rf10_cleared");

    tick();
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d checks never compared, want 0", sb.size());
      total = total + sb.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
